// File: rtl/alu_frame_serializer.sv
`default_nettype none
// ============================================================================
// Module   : alu_frame_serializer
// Purpose  : Downstream stage of the ALU core. Serializes a 55-bit result
//            packet (5 frames x 11 bits, {start 0, type, data[7:0], stop 1})
//            onto a single line, MSB first. One packet can be held pending
//            behind the one on the wire; a third strobe is dropped and
//            flagged as an overrun.
// Ports    : clk        - clock
//            rst_n      - reset, asynchronous, active-high
//            data_in    - 55-bit packet, bit 54 sent first
//            data_valid - 1-cycle strobe qualifying data_in
//            sout       - serial output, idles high
//            busy       - transmit in progress
//            pending    - holding buffer occupied
//            done       - 1-cycle pulse after a packet's last bit period
//            overrun    - 1-cycle pulse when a strobe is dropped
// Revision : 1.0 - initial release
// ============================================================================
module alu_frame_serializer #(
    parameter int CLKS_PER_BIT = 1,
    parameter int IFG_BITS     = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [54:0] data_in,
    input  logic        data_valid,
    output logic        sout,
    output logic        busy,
    output logic        pending,
    output logic        done,
    output logic        overrun
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int C_CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int C_GAP_CYC = IFG_BITS * CLKS_PER_BIT;
    localparam int C_GW      = (C_GAP_CYC > 1) ? $clog2(C_GAP_CYC) : 1;
    localparam bit C_HAS_GAP = (IFG_BITS > 0);

    localparam logic [C_CW-1:0] C_CPB_M1   = C_CW'(CLKS_PER_BIT - 1);
    localparam logic [C_CW-1:0] C_CLK_ONE  = C_CW'(1);
    localparam logic [C_GW-1:0] C_GAP_M1   = C_GW'((C_GAP_CYC > 0) ? (C_GAP_CYC - 1) : 0);
    localparam logic [C_GW-1:0] C_GAP_ONE  = C_GW'(1);
    localparam logic [3:0]      C_LAST_BIT = 4'd10;
    localparam logic [2:0]      C_LAST_FRM = 3'd4;

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [54:0]     r_shreg,   w_shreg_nxt;
    logic [54:0]     r_hold,    w_hold_nxt;
    logic            r_pending, w_pending_nxt;
    logic [C_CW-1:0] r_clk_cnt, w_clk_cnt_nxt;
    logic [3:0]      r_bit_cnt, w_bit_cnt_nxt;
    logic [2:0]      r_frm_cnt, w_frm_cnt_nxt;
    logic [C_GW-1:0] r_gap_cnt, w_gap_cnt_nxt;
    logic            r_done,    w_done_nxt;
    logic            r_overrun, w_overrun_nxt;

    logic            w_bit_end;
    logic            w_strobe_taken;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_shreg   <= '0;
            r_hold    <= '0;
            r_pending <= 1'b0;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_frm_cnt <= '0;
            r_gap_cnt <= '0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_shreg   <= w_shreg_nxt;
            r_hold    <= w_hold_nxt;
            r_pending <= w_pending_nxt;
            r_clk_cnt <= w_clk_cnt_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_frm_cnt <= w_frm_cnt_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            r_done    <= w_done_nxt;
            r_overrun <= w_overrun_nxt;
        end
    end

    assign w_bit_end = (r_state == S_SHIFT) && (r_clk_cnt == C_CPB_M1);

    // ------------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_shreg_nxt    = r_shreg;
        w_hold_nxt     = r_hold;
        w_pending_nxt  = r_pending;
        w_clk_cnt_nxt  = r_clk_cnt;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_frm_cnt_nxt  = r_frm_cnt;
        w_gap_cnt_nxt  = r_gap_cnt;
        w_done_nxt     = 1'b0;
        w_overrun_nxt  = 1'b0;
        w_strobe_taken = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (data_valid) begin
                    w_state_nxt    = S_SHIFT;
                    w_shreg_nxt    = data_in;
                    w_strobe_taken = 1'b1;
                    w_clk_cnt_nxt  = '0;
                    w_bit_cnt_nxt  = '0;
                    w_frm_cnt_nxt  = '0;
                    w_gap_cnt_nxt  = '0;
                end
            end

            S_SHIFT: begin
                if (w_bit_end) begin
                    w_clk_cnt_nxt = '0;
                    w_shreg_nxt   = {r_shreg[53:0], 1'b0};
                    w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    if (r_bit_cnt == C_LAST_BIT) begin
                        w_bit_cnt_nxt = '0;
                        if (r_frm_cnt == C_LAST_FRM) begin
                            // Packet end: chain straight into the next packet
                            // when one is available so the line never idles.
                            w_done_nxt    = 1'b1;
                            w_frm_cnt_nxt = '0;
                            if (r_pending) begin
                                w_shreg_nxt   = r_hold;
                                w_pending_nxt = 1'b0;
                            end else if (data_valid) begin
                                w_shreg_nxt    = data_in;
                                w_strobe_taken = 1'b1;
                            end else begin
                                w_state_nxt = S_IDLE;
                            end
                        end else if (C_HAS_GAP) begin
                            // Frame counter advances on gap exit.
                            w_state_nxt   = S_GAP;
                            w_gap_cnt_nxt = '0;
                        end else begin
                            w_frm_cnt_nxt = r_frm_cnt + 3'd1;
                        end
                    end
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + C_CLK_ONE;
                end
            end

            S_GAP: begin
                if (r_gap_cnt == C_GAP_M1) begin
                    w_state_nxt   = S_SHIFT;
                    w_gap_cnt_nxt = '0;
                    w_bit_cnt_nxt = '0;
                    w_frm_cnt_nxt = r_frm_cnt + 3'd1;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + C_GAP_ONE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // A strobe not consumed by the shifter goes to the holding buffer.
        // Checking the post-update pending flag lets a strobe at the
        // packet-end edge refill the buffer that is being drained.
        if (data_valid && !w_strobe_taken) begin
            if (!w_pending_nxt) begin
                w_hold_nxt    = data_in;
                w_pending_nxt = 1'b1;
            end else begin
                w_overrun_nxt = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // During a gap the shift register already holds the next frame's start
    // bit, so the line must be forced high outside SHIFT.
    assign sout    = (r_state == S_SHIFT) ? r_shreg[54] : 1'b1;
    assign busy    = (r_state != S_IDLE);
    assign pending = r_pending;
    assign done    = r_done;
    assign overrun = r_overrun;

endmodule
`default_nettype wire
